// File: rtl/ps2_keyq.sv
// Keystroke queue behind the PS/2 receiver: captures key words, acks them,
// optionally translates set-2 codes to ASCII and buffers them for the CPU.
module ps2_keyq #(
  parameter int DEPTH_LOG2 = 3,
  parameter bit XLATE      = 1'b1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [8:0]            kin,
  output logic                  kack,
  input  logic                  rd,
  output logic [7:0]            dout,
  output logic                  empty,
  output logic                  full,
  output logic [DEPTH_LOG2:0]   count,
  output logic                  ovf,
  input  logic                  clr_ovf
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_XLAT = 2'd1;
  localparam logic [1:0] S_ACK  = 2'd2;
  localparam logic [1:0] S_WAIT = 2'd3;

  localparam logic [DEPTH_LOG2-1:0] PTR_ONE  = DEPTH_LOG2'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_ONE  = (DEPTH_LOG2+1)'(1);
  localparam logic [DEPTH_LOG2:0]   CNT_FULL = (DEPTH_LOG2+1)'(DEPTH);

  logic [1:0]            state_q, state_d;
  logic [7:0]            code_q, code_d;
  logic [DEPTH_LOG2-1:0] wptr_q, wptr_d;
  logic [DEPTH_LOG2-1:0] rptr_q, rptr_d;
  logic [DEPTH_LOG2:0]   cnt_q, cnt_d;
  logic                  empty_q, empty_d;
  logic                  full_q, full_d;
  logic                  ovf_q, ovf_d;
  logic [7:0]            mem_q [DEPTH];

  logic [7:0] asc;
  logic       hit;
  logic [7:0] wval;
  logic       wok;
  logic       push_req;
  logic       push;
  logic       pop;
  logic       lost;

  always_comb begin
    asc = 8'h00;
    hit = 1'b1;
    case (code_q)
      8'h1C: asc = 8'h61;
      8'h32: asc = 8'h62;
      8'h21: asc = 8'h63;
      8'h23: asc = 8'h64;
      8'h24: asc = 8'h65;
      8'h2B: asc = 8'h66;
      8'h34: asc = 8'h67;
      8'h33: asc = 8'h68;
      8'h43: asc = 8'h69;
      8'h3B: asc = 8'h6A;
      8'h42: asc = 8'h6B;
      8'h4B: asc = 8'h6C;
      8'h3A: asc = 8'h6D;
      8'h31: asc = 8'h6E;
      8'h44: asc = 8'h6F;
      8'h4D: asc = 8'h70;
      8'h15: asc = 8'h71;
      8'h2D: asc = 8'h72;
      8'h1B: asc = 8'h73;
      8'h2C: asc = 8'h74;
      8'h3C: asc = 8'h75;
      8'h2A: asc = 8'h76;
      8'h1D: asc = 8'h77;
      8'h22: asc = 8'h78;
      8'h35: asc = 8'h79;
      8'h1A: asc = 8'h7A;
      8'h45: asc = 8'h30;
      8'h16: asc = 8'h31;
      8'h1E: asc = 8'h32;
      8'h26: asc = 8'h33;
      8'h25: asc = 8'h34;
      8'h2E: asc = 8'h35;
      8'h36: asc = 8'h36;
      8'h3D: asc = 8'h37;
      8'h3E: asc = 8'h38;
      8'h46: asc = 8'h39;
      8'h29: asc = 8'h20;
      8'h5A: asc = 8'h0D;
      8'h66: asc = 8'h08;
      default: hit = 1'b0;
    endcase
    wval = XLATE ? asc : code_q;
    wok  = XLATE ? hit : 1'b1;
  end

  always_comb begin
    push_req = (state_q == S_XLAT) && wok;
    pop      = rd && !empty_q;
    // A pop in the same cycle frees the slot a full FIFO needs.
    push     = push_req && (!full_q || pop);
    lost     = push_req && full_q && !pop;

    wptr_d = push ? wptr_q + PTR_ONE : wptr_q;
    rptr_d = pop ? rptr_q + PTR_ONE : rptr_q;

    cnt_d = cnt_q;
    if (push && !pop)
      cnt_d = cnt_q + CNT_ONE;
    else if (pop && !push)
      cnt_d = cnt_q - CNT_ONE;

    empty_d = (cnt_d == '0);
    full_d  = (cnt_d == CNT_FULL);

    ovf_d = ovf_q;
    if (lost)
      ovf_d = 1'b1;
    else if (clr_ovf)
      ovf_d = 1'b0;

    state_d = state_q;
    code_d  = code_q;
    case (state_q)
      S_IDLE: begin
        if (kin[8]) begin
          code_d  = kin[7:0];
          state_d = S_XLAT;
        end
      end
      S_XLAT:  state_d = S_ACK;
      S_ACK:   state_d = S_WAIT;
      default: begin
        if (!kin[8])
          state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      code_q  <= 8'h00;
      wptr_q  <= '0;
      rptr_q  <= '0;
      cnt_q   <= '0;
      empty_q <= 1'b1;
      full_q  <= 1'b0;
      ovf_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      code_q  <= code_d;
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      cnt_q   <= cnt_d;
      empty_q <= empty_d;
      full_q  <= full_d;
      ovf_q   <= ovf_d;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && push)
      mem_q[wptr_q] <= wval;
  end

  assign kack  = (state_q == S_ACK);
  assign dout  = empty_q ? 8'h00 : mem_q[rptr_q];
  assign empty = empty_q;
  assign full  = full_q;
  assign count = cnt_q;
  assign ovf   = ovf_q;

endmodule
